// File: rtl/keypad_pkg.sv
// Shared key codes and FSM state encoding for the keypad entry controller.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB,
        SUBMIT
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// Tick-qualified consecutive-sample counter; shared by press and release qualification.
module key_debounce #(
    parameter int TICKS = 3
) (
    input  logic clock,
    input  logic resetn,
    input  logic sample_tick,
    input  logic run,
    input  logic match,
    output logic hit
);

    localparam int CW = $clog2(TICKS + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW:0]   count_inc;

    // run=0 drops the count, match=0 restarts it at one with the new sample
    always_comb begin
        count_inc = {1'b0, count_q} + (CW+1)'(1);
        count_d   = count_q;
        hit       = 1'b0;
        if (sample_tick) begin
            if (!run) begin
                count_d = '0;
            end else if (!match) begin
                count_d = CW'(1);
            end else begin
                count_d = count_inc[CW-1:0];
                hit     = (count_inc >= (CW+1)'(TICKS));
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: debounced presses -> digit/clear/submit actions -> valid/ready entry.
// Optional inactivity timeout enabled with `define KEYPAD_TIMEOUT_EN.
//   state      | meaning
//   IDLE       | no key down, waiting for a valid sample
//   PRESS_DB   | qualifying a candidate key code
//   HELD       | press accepted, waiting for release
//   RELEASE_DB | qualifying the release
//   SUBMIT     | entry presented, waiting for entry_ready
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 3,
    parameter int MAX_DIGITS     = 4,
    parameter int VALUE_W        = 14,
    parameter int TIMEOUT_TICKS  = 1000
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               sample_tick,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    input  logic               entry_ready,
    output logic               entry_valid,
    output logic [VALUE_W-1:0] entry_value,
    output logic [3:0]         digit_count,
    output logic               key_event,
    output logic [3:0]         key_event_code,
    output logic               err
);

    state_t               state_q, state_d;
    logic [3:0]           cand_q, cand_d;
    logic [VALUE_W-1:0]   value_q, value_d;
    logic [3:0]           digits_q, digits_d;
    logic                 key_event_q, key_event_d;
    logic [3:0]           event_code_q, event_code_d;
    logic                 err_q, err_d;
    logic                 entry_valid_q, entry_valid_d;
    logic [VALUE_W+3:0]   mac;
    logic                 db_run, db_match, db_hit;

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] idle_left_q, idle_left_d;
`else
    localparam int unused_timeout_ticks = TIMEOUT_TICKS;
`endif

    key_debounce #(.TICKS(DEBOUNCE_TICKS)) u_debounce (
        .clock       (clock),
        .resetn      (resetn),
        .sample_tick (sample_tick),
        .run         (db_run),
        .match       (db_match),
        .hit         (db_hit)
    );

    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        value_d       = value_q;
        digits_d      = digits_q;
        event_code_d  = event_code_q;
        entry_valid_d = entry_valid_q;
        key_event_d   = 1'b0;
        err_d         = 1'b0;
        db_run        = 1'b0;
        db_match      = 1'b0;
        mac = ({4'd0, value_q} << 3) + ({4'd0, value_q} << 1) + {{VALUE_W{1'b0}}, cand_q};

        case (state_q)
            IDLE: begin
                db_run = key_valid;
                if (sample_tick && key_valid) begin
                    cand_d  = key_code;
                    state_d = PRESS_DB;
                end
            end
            PRESS_DB: begin
                db_run   = key_valid;
                db_match = (key_code == cand_q);
                if (sample_tick) begin
                    if (!key_valid) begin
                        state_d = IDLE;
                    end else if (!db_match) begin
                        cand_d = key_code;
                    end else if (db_hit) begin
                        key_event_d  = 1'b1;
                        event_code_d = cand_q;
                        state_d      = HELD;
                        if (cand_q <= 4'd9) begin
                            if (digits_q < 4'(MAX_DIGITS)) begin
                                value_d  = VALUE_W'(mac);
                                digits_d = digits_q + 4'd1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (cand_q == KEY_STAR) begin
                            value_d  = '0;
                            digits_d = '0;
                        end else if (cand_q == KEY_HASH) begin
                            if (digits_q == 4'd0) begin
                                err_d = 1'b1;
                            end else begin
                                entry_valid_d = 1'b1;
                                state_d       = SUBMIT;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            HELD: begin
                db_run = !key_valid;
                if (sample_tick && !key_valid) begin
                    state_d = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                db_run   = !key_valid;
                db_match = 1'b1;
                if (sample_tick) begin
                    if (key_valid) begin
                        state_d = HELD;
                    end else if (db_hit) begin
                        state_d = IDLE;
                    end
                end
            end
            SUBMIT: begin
                // the '#' key is usually still down here, so go via HELD
                if (entry_valid_q && entry_ready) begin
                    entry_valid_d = 1'b0;
                    value_d       = '0;
                    digits_d      = '0;
                    state_d       = HELD;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef KEYPAD_TIMEOUT_EN
        idle_left_d = idle_left_q;
        if (key_event_d) begin
            idle_left_d = TW'(TIMEOUT_TICKS);
        end else if (state_q == IDLE && digits_q != 4'd0 && sample_tick) begin
            if (idle_left_q <= TW'(1)) begin
                value_d     = '0;
                digits_d    = '0;
                err_d       = 1'b1;
                idle_left_d = TW'(TIMEOUT_TICKS);
            end else begin
                idle_left_d = idle_left_q - TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cand_q        <= '0;
            value_q       <= '0;
            digits_q      <= '0;
            key_event_q   <= 1'b0;
            event_code_q  <= '0;
            err_q         <= 1'b0;
            entry_valid_q <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
            idle_left_q   <= TW'(TIMEOUT_TICKS);
`endif
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            value_q       <= value_d;
            digits_q      <= digits_d;
            key_event_q   <= key_event_d;
            event_code_q  <= event_code_d;
            err_q         <= err_d;
            entry_valid_q <= entry_valid_d;
`ifdef KEYPAD_TIMEOUT_EN
            idle_left_q   <= idle_left_d;
`endif
        end
    end

    assign entry_valid    = entry_valid_q;
    assign entry_value    = value_q;
    assign digit_count    = digits_q;
    assign key_event      = key_event_q;
    assign key_event_code = event_code_q;
    assign err            = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl: press table plus hand-written corner sequences.
module tb_keypad_entry_ctrl;

    localparam int VW = 14;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          sample_tick = 1'b0;
    logic          key_valid = 1'b0;
    logic [3:0]    key_code = 4'd0;
    logic          entry_ready = 1'b0;
    logic          entry_valid;
    logic [VW-1:0] entry_value;
    logic [3:0]    digit_count;
    logic          key_event;
    logic [3:0]    key_event_code;
    logic          err;

    keypad_entry_ctrl #(
        .DEBOUNCE_TICKS (3),
        .MAX_DIGITS     (4),
        .VALUE_W        (VW),
        .TIMEOUT_TICKS  (20)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .sample_tick    (sample_tick),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .entry_ready    (entry_ready),
        .entry_valid    (entry_valid),
        .entry_value    (entry_value),
        .digit_count    (digit_count),
        .key_event      (key_event),
        .key_event_code (key_event_code),
        .err            (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         ev;
        logic [3:0] code;
        bit         er;
        int         value;
        int         count;
        bit         valid;
    } exp_t;

    typedef struct {
        logic [3:0] code;
        bit         er;
        int         value;
        int         count;
    } vec_t;

    exp_t ev_q[$];
    int   ent_q[$];
    exp_t mon_e;
    int   mon_v;
    vec_t tbl[19];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick(input bit v, input logic [3:0] c);
        key_valid   = v;
        key_code    = c;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
    endtask

    task automatic press(input logic [3:0] c, input exp_t e);
        tick(1'b1, c);
        tick(1'b1, c);
        ev_q.push_back(e);
        tick(1'b1, c);
        for (int i = 0; i < 3; i++) tick(1'b0, c);
    endtask

    // Scoreboard: every pulse on key_event/err and every handshake must match a queued expectation
    always @(negedge clock) begin
        if (key_event === 1'b1 || err === 1'b1) begin
            if (ev_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: got key_event=%0d err=%0d code=%0d value=%0d, expected no pulse",
                         key_event, err, key_event_code, entry_value);
            end else begin
                mon_e = ev_q.pop_front();
                chk("key_event", 32'(key_event), 32'(mon_e.ev));
                if (mon_e.ev) chk("key_event_code", 32'(key_event_code), 32'(mon_e.code));
                chk("err", 32'(err), 32'(mon_e.er));
                chk("entry_value", 32'(entry_value), mon_e.value);
                chk("digit_count", 32'(digit_count), mon_e.count);
                chk("entry_valid_at_event", 32'(entry_valid), 32'(mon_e.valid));
            end
        end
        if (entry_valid === 1'b1 && entry_ready === 1'b1) begin
            if (ent_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_handshake: got value=%0d, expected no handshake", entry_value);
            end else begin
                mon_v = ent_q.pop_front();
                chk("handshake_value", 32'(entry_value), mon_v);
            end
        end
    end

    initial begin
        tbl[0]  = '{4'd5,  1'b0, 5,    1};
        tbl[1]  = '{4'd10, 1'b0, 0,    0};
        tbl[2]  = '{4'd1,  1'b0, 1,    1};
        tbl[3]  = '{4'd2,  1'b0, 12,   2};
        tbl[4]  = '{4'd3,  1'b0, 123,  3};
        tbl[5]  = '{4'd4,  1'b0, 1234, 4};
        tbl[6]  = '{4'd9,  1'b1, 1234, 4};
        tbl[7]  = '{4'd12, 1'b1, 1234, 4};
        tbl[8]  = '{4'd10, 1'b0, 0,    0};
        tbl[9]  = '{4'd11, 1'b1, 0,    0};
        tbl[10] = '{4'd8,  1'b0, 8,    1};
        tbl[11] = '{4'd8,  1'b0, 88,   2};
        tbl[12] = '{4'd10, 1'b0, 0,    0};
        tbl[13] = '{4'd15, 1'b1, 0,    0};
        tbl[14] = '{4'd9,  1'b0, 9,    1};
        tbl[15] = '{4'd9,  1'b0, 99,   2};
        tbl[16] = '{4'd9,  1'b0, 999,  3};
        tbl[17] = '{4'd9,  1'b0, 9999, 4};
        tbl[18] = '{4'd10, 1'b0, 0,    0};

        repeat (3) step();
        chk("rst_entry_valid", 32'(entry_valid), 0);
        chk("rst_entry_value", 32'(entry_value), 0);
        chk("rst_digit_count", 32'(digit_count), 0);
        chk("rst_key_event", 32'(key_event), 0);
        chk("rst_key_event_code", 32'(key_event_code), 0);
        chk("rst_err", 32'(err), 0);
        resetn = 1'b1;
        step();

        // entry_ready held high with nothing pending must have no effect
        entry_ready = 1'b1;
        for (int i = 0; i < 19; i++) begin
            press(tbl[i].code, '{1'b1, tbl[i].code, tbl[i].er, tbl[i].value, tbl[i].count, 1'b0});
            chk("tbl_value_after", 32'(entry_value), tbl[i].value);
        end

        // glitching 7: restart on the invalid sample, then one event even when held long
        tick(1'b1, 4'd7);
        tick(1'b0, 4'd7);
        tick(1'b1, 4'd7);
        tick(1'b1, 4'd7);
        ev_q.push_back('{1'b1, 4'd7, 1'b0, 7, 1, 1'b0});
        tick(1'b1, 4'd7);
        for (int i = 0; i < 6; i++) tick(1'b1, 4'd7);
        for (int i = 0; i < 3; i++) tick(1'b0, 4'd7);

        // code change mid-debounce relatches; release bounce must not re-trigger
        tick(1'b1, 4'd3);
        tick(1'b1, 4'd6);
        tick(1'b1, 4'd6);
        ev_q.push_back('{1'b1, 4'd6, 1'b0, 76, 2, 1'b0});
        tick(1'b1, 4'd6);
        tick(1'b0, 4'd6);
        tick(1'b0, 4'd6);
        tick(1'b1, 4'd6);
        for (int i = 0; i < 3; i++) tick(1'b0, 4'd6);
        press(4'd10, '{1'b1, 4'd10, 1'b0, 0, 0, 1'b0});

        // submit 42 with a stalled consumer
        entry_ready = 1'b0;
        press(4'd4, '{1'b1, 4'd4, 1'b0, 4, 1, 1'b0});
        press(4'd2, '{1'b1, 4'd2, 1'b0, 42, 2, 1'b0});
        tick(1'b1, 4'd11);
        tick(1'b1, 4'd11);
        ev_q.push_back('{1'b1, 4'd11, 1'b0, 42, 2, 1'b1});
        tick(1'b1, 4'd11);
        for (int i = 0; i < 10; i++) begin
            chk("submit_hold_valid", 32'(entry_valid), 1);
            chk("submit_hold_value", 32'(entry_value), 42);
            step();
        end
        ent_q.push_back(42);
        entry_ready = 1'b1;
        step();
        entry_ready = 1'b0;
        chk("post_hs_valid", 32'(entry_valid), 0);
        chk("post_hs_value", 32'(entry_value), 0);
        chk("post_hs_count", 32'(digit_count), 0);
        for (int i = 0; i < 3; i++) tick(1'b1, 4'd11);
        for (int i = 0; i < 3; i++) tick(1'b0, 4'd11);
        press(4'd1, '{1'b1, 4'd1, 1'b0, 1, 1, 1'b0});

        // asynchronous reset while an entry is pending
        press(4'd6, '{1'b1, 4'd6, 1'b0, 16, 2, 1'b0});
        tick(1'b1, 4'd11);
        tick(1'b1, 4'd11);
        ev_q.push_back('{1'b1, 4'd11, 1'b0, 16, 2, 1'b1});
        tick(1'b1, 4'd11);
        step();
        chk("pre_reset_valid", 32'(entry_valid), 1);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_rst_valid", 32'(entry_valid), 0);
        chk("async_rst_value", 32'(entry_value), 0);
        chk("async_rst_count", 32'(digit_count), 0);
        chk("async_rst_code", 32'(key_event_code), 0);
        key_valid = 1'b0;
        step();
        step();
        resetn = 1'b1;
        repeat (3) step();
        chk("after_rst_valid", 32'(entry_valid), 0);

`ifdef KEYPAD_TIMEOUT_EN
        press(4'd3, '{1'b1, 4'd3, 1'b0, 3, 1, 1'b0});
        for (int i = 0; i < 19; i++) tick(1'b0, 4'd0);
        chk("pre_timeout_value", 32'(entry_value), 3);
        ev_q.push_back('{1'b0, 4'd0, 1'b1, 0, 0, 1'b0});
        tick(1'b0, 4'd0);
        chk("timeout_value", 32'(entry_value), 0);
        chk("timeout_count", 32'(digit_count), 0);
`else
        press(4'd3, '{1'b1, 4'd3, 1'b0, 3, 1, 1'b0});
        for (int i = 0; i < 30; i++) tick(1'b0, 4'd0);
        chk("persist_value", 32'(entry_value), 3);
        chk("persist_count", 32'(digit_count), 1);
`endif

        repeat (4) step();
        chk("sb_events_left", 32'(ev_q.size()), 0);
        chk("sb_entries_left", 32'(ent_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequences raw keypad scan results into complete numeric entries for the ATM coin machine. Takes the scanner's per-sample key code, debounces press and release, and applies one action per physical press: digit append, clear (`*`) or submit (`#`). Accumulates a binary amount and hands it to the processor-side transaction logic over a valid/ready handshake.

## Interface
- `DEBOUNCE_TICKS`, default 3: consecutive identical `sample_tick` samples required to accept a press or a release.
- `MAX_DIGITS`, default 4: maximum digits per entry.
- `VALUE_W`, default 14: width of the accumulated value; must hold 10^MAX_DIGITS − 1.
- `TIMEOUT_TICKS`, default 1000: inactivity timeout in `sample_tick`s. Only used when `KEYPAD_TIMEOUT_EN` is defined.
- `clock` in 1: single system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `sample_tick` in 1: one-cycle strobe from the 100 Hz keypad divider; inputs are sampled only on a tick.
- `key_valid` in 1: a key is currently detected by the scanner.
- `key_code` in 4: 0–9 are digits, 10 is `*`, 11 is `#`, 12–15 are illegal.
- `entry_ready` in 1: the consumer accepts the entry.
- `entry_valid` out 1: a submitted entry is pending.
- `entry_value` out VALUE_W: the submitted or in-progress value.
- `digit_count` out 4: number of digits currently held.
- `key_event` out 1: one-cycle pulse when a press is accepted.
- `key_event_code` out 4: code of the last accepted press.
- `err` out 1: one-cycle pulse when a press is rejected.

## Operation
- Reset values: state IDLE; all outputs 0; debounce counter 0.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB, SUBMIT.
- IDLE: on a tick with `key_valid`=1, latch `key_code` as the candidate, set count to 1, and go to PRESS_DB.
- PRESS_DB, on each tick:
  - Same code still valid: increment the count.
  - Code differs: re-latch the candidate and set count to 1.
  - `key_valid`=0: return to IDLE.
  - Count reaches `DEBOUNCE_TICKS`: accept the press, pulse `key_event`, execute the action, and go to HELD. If the action is a submit, go to SUBMIT instead.
- Actions:
  - Digit d with `digit_count` < MAX_DIGITS: value ← value·10 + d; `digit_count`+1.
  - Digit at MAX_DIGITS: value unchanged; pulse `err`.
  - `*`: value ← 0; `digit_count` ← 0.
  - `#` with `digit_count`=0: ignored; pulse `err`.
  - `#` with `digit_count`>0: assert `entry_valid`.
  - Codes 12–15: no action; pulse `err`; `key_event` still pulses.
- HELD: on a tick with `key_valid`=0, count 1 and go to RELEASE_DB.
- RELEASE_DB: `DEBOUNCE_TICKS` consecutive ticks with `key_valid`=0 return to IDLE. Any tick with `key_valid`=1 returns to HELD. No new press is accepted until release completes, so a held key produces exactly one event.
- SUBMIT:
  - `entry_valid` and `entry_value` stay stable; key input is ignored.
  - On `entry_valid`&`entry_ready`, clear value and `digit_count` and go to HELD. The `#` key must still be released.
- Arithmetic: the multiply-accumulate is done at VALUE_W+4 bits and truncated. The parameter constraint guarantees no overflow.

## Timing
- An accepted press acts in the same cycle as the qualifying tick. `key_event`, `err`, `entry_valid`, `entry_value` and `digit_count` are all registered, so they update on the next edge.
- Minimum press-to-event time is DEBOUNCE_TICKS ticks.
- `entry_valid` rises 1 cycle after the accepting tick. It stays high until the handshake and drops on the clock after it.
- `entry_ready` while `entry_valid`=0 has no effect.
- A `sample_tick` coinciding with the handshake cycle is ignored.
- Asynchronous reset mid-entry or mid-SUBMIT discards the entry immediately; there is no pending `entry_valid` after reset.

## Configuration
- `KEYPAD_TIMEOUT_EN` defined:
  - An idle counter counts ticks in IDLE while `digit_count`>0.
  - It resets on any accepted press.
  - At TIMEOUT_TICKS it clears value and `digit_count` and pulses `err`.
  - The timeout is inactive in SUBMIT.
- `KEYPAD_TIMEOUT_EN` undefined: no counter; a partial entry persists indefinitely.

## Structure
- Shared package `keypad_pkg`:
  - Key code constants `KEY_STAR`=10 and `KEY_HASH`=11.
  - FSM state enum.
- One sub-module, `key_debounce`: the tick-qualified consecutive-sample counter, instantiated once. The FSM reuses it for both press and release qualification.

## Test plan
- Press 5 held for 3 ticks, release for 3 ticks: exactly one `key_event` with code 5; `entry_value`=5, `digit_count`=1.
- Key 7 glitching valid–invalid–valid across ticks: no event until 3 consecutive valid ticks.
- Keys 1,2,3,4 then 9: value 1234; the press of 9 pulses `err`; value stays 1234.
- Keys 4,2 then `#`, with `entry_ready` low for 10 cycles: `entry_valid` holds value 42. Raising `entry_ready` clears the entry next cycle; no second event until `#` is released.
- `#` with an empty buffer pulses `err` with no `entry_valid`. `*` after 8,8 gives value 0, count 0.
- `resetn` low during SUBMIT: all outputs 0 asynchronously. With `KEYPAD_TIMEOUT_EN` and TIMEOUT_TICKS=20, digit 3 then 20 idle ticks clears the value and pulses `err`.
